// File: rtl/sc_leveltimer_if.sv
// rtl/sc_leveltimer_if.sv - start/crash controls and tick/level/status outputs of the level timer
interface sc_leveltimer_if #(
  parameter int LEVEL_WIDTH = 8
);
  logic                   SC_LEVELTIMER_START_InLow;
  logic                   SC_LEVELTIMER_CRASH_InHigh;
  logic                   SC_LEVELTIMER_TICK_OutHigh;
  logic [LEVEL_WIDTH-1:0] SC_LEVELTIMER_LEVEL_Out;
  logic [1:0]             SC_LEVELTIMER_BAND_Out;
  logic                   SC_LEVELTIMER_RUNNING_OutHigh;
  logic                   SC_LEVELTIMER_DONE_OutHigh;

  modport master (
    output SC_LEVELTIMER_START_InLow,
    output SC_LEVELTIMER_CRASH_InHigh,
    input  SC_LEVELTIMER_TICK_OutHigh,
    input  SC_LEVELTIMER_LEVEL_Out,
    input  SC_LEVELTIMER_BAND_Out,
    input  SC_LEVELTIMER_RUNNING_OutHigh,
    input  SC_LEVELTIMER_DONE_OutHigh
  );

  modport slave (
    input  SC_LEVELTIMER_START_InLow,
    input  SC_LEVELTIMER_CRASH_InHigh,
    output SC_LEVELTIMER_TICK_OutHigh,
    output SC_LEVELTIMER_LEVEL_Out,
    output SC_LEVELTIMER_BAND_Out,
    output SC_LEVELTIMER_RUNNING_OutHigh,
    output SC_LEVELTIMER_DONE_OutHigh
  );
endinterface

// File: rtl/sc_leveltimer.sv
// rtl/sc_leveltimer.sv - level-paced tick generator with saturating level counter and run/pause/done FSM
module sc_leveltimer #(
  parameter int TIMER_WIDTH = 25,
  parameter int LEVEL_WIDTH = 8,
  parameter int PERIOD_L1   = 17500000,
  parameter int PERIOD_L2   = 15000000,
  parameter int PERIOD_L3   = 12500000,
  parameter int LV_TH1      = 10,
  parameter int LV_TH2      = 32,
  parameter int LV_MAX      = 59
) (
  input  logic           SC_LEVELTIMER_CLOCK_50,
  input  logic           SC_LEVELTIMER_RESET_InHigh,
  sc_leveltimer_if.slave bus
);

  localparam logic [TIMER_WIDTH-1:0] P1_M1  = TIMER_WIDTH'(PERIOD_L1 - 1);
  localparam logic [TIMER_WIDTH-1:0] P2_M1  = TIMER_WIDTH'(PERIOD_L2 - 1);
  localparam logic [TIMER_WIDTH-1:0] P3_M1  = TIMER_WIDTH'(PERIOD_L3 - 1);
  localparam logic [LEVEL_WIDTH-1:0] TH1_V  = LEVEL_WIDTH'(LV_TH1);
  localparam logic [LEVEL_WIDTH-1:0] TH2_V  = LEVEL_WIDTH'(LV_TH2);
  localparam logic [LEVEL_WIDTH-1:0] LVMX_V = LEVEL_WIDTH'(LV_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t                 state, state_n;
  logic [TIMER_WIDTH-1:0] timer, timer_n, period_m1;
  logic [LEVEL_WIDTH-1:0] lv, lv_n, lv_inc;
  logic                   tick, tick_n;
  logic                   start_prev, start_press;
  logic [1:0]             band;

  assign start_press = start_prev & ~bus.SC_LEVELTIMER_START_InLow;
  assign lv_inc      = lv + 1'b1;

  // Band follows the registered level, so a period change lands exactly on a tick.
  always_comb begin
    band      = 2'd2;
    period_m1 = P3_M1;
    if (lv <= TH1_V) begin
      band      = 2'd0;
      period_m1 = P1_M1;
    end else if (lv <= TH2_V) begin
      band      = 2'd1;
      period_m1 = P2_M1;
    end
  end

  always_ff @(posedge SC_LEVELTIMER_CLOCK_50) begin
    if (SC_LEVELTIMER_RESET_InHigh) begin
      state      <= ST_IDLE;
      timer      <= '0;
      lv         <= '0;
      tick       <= 1'b0;
      start_prev <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      lv         <= lv_n;
      tick       <= tick_n;
      start_prev <= bus.SC_LEVELTIMER_START_InLow;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    lv_n    = lv;
    tick_n  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_press) begin
          state_n = ST_RUN;
          timer_n = '0;
          lv_n    = '0;
        end
      end
      ST_RUN: begin
        if (bus.SC_LEVELTIMER_CRASH_InHigh) begin
          state_n = ST_PAUSE;
        end else if (timer == period_m1) begin
          timer_n = '0;
          tick_n  = 1'b1;
          lv_n    = lv_inc;
          if (lv_inc == LVMX_V) state_n = ST_DONE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!bus.SC_LEVELTIMER_CRASH_InHigh) state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.SC_LEVELTIMER_TICK_OutHigh    = tick;
  assign bus.SC_LEVELTIMER_LEVEL_Out       = lv;
  assign bus.SC_LEVELTIMER_BAND_Out        = band;
  assign bus.SC_LEVELTIMER_RUNNING_OutHigh = (state == ST_RUN);
  assign bus.SC_LEVELTIMER_DONE_OutHigh    = (state == ST_DONE);

endmodule

// File: tb/tb_sc_leveltimer.sv
// tb/tb_sc_leveltimer.sv - directed table-driven bench for sc_leveltimer with small periods
module tb_sc_leveltimer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sc_leveltimer_if #(.LEVEL_WIDTH(8)) bus ();

  sc_leveltimer #(
    .TIMER_WIDTH(25), .LEVEL_WIDTH(8),
    .PERIOD_L1(4), .PERIOD_L2(3), .PERIOD_L3(2),
    .LV_TH1(2), .LV_TH2(4), .LV_MAX(6)
  ) dut (
    .SC_LEVELTIMER_CLOCK_50     (clk),
    .SC_LEVELTIMER_RESET_InHigh (rst),
    .bus                        (bus)
  );

  typedef struct {
    logic rst;
    logic start;
    logic crash;
    logic tick;
    int   lv;
    int   band;
    logic run;
    logic done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic c, input logic t,
                     input int l, input int b, input logic ru, input logic d);
    vec_t v;
    v.rst = r; v.start = s; v.crash = c; v.tick = t;
    v.lv = l; v.band = b; v.run = ru; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input int l, input int b,
                         input int ru, input int d);
    chk({tag, ".tick"},    int'(bus.SC_LEVELTIMER_TICK_OutHigh), t);
    chk({tag, ".level"},   int'(bus.SC_LEVELTIMER_LEVEL_Out), l);
    chk({tag, ".band"},    int'(bus.SC_LEVELTIMER_BAND_Out), b);
    chk({tag, ".running"}, int'(bus.SC_LEVELTIMER_RUNNING_OutHigh), ru);
    chk({tag, ".done"},    int'(bus.SC_LEVELTIMER_DONE_OutHigh), d);
  endtask

  initial begin
    int n;
    int ticks;
    int entries;
    logic prev_run;
    logic found;

    bus.SC_LEVELTIMER_START_InLow  = 1'b1;
    bus.SC_LEVELTIMER_CRASH_InHigh = 1'b0;

    // Basic run: P1=4 for LV 1..3, P2=3 for LV 4..5, P3=2 for LV 6.
    add(1,1,0, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(0,0,0, 0,0,0,1,0);
    for (int i = 0; i < 3; i++) add(0,1,0, 0,0,0,1,0);
    add(0,1,0, 1,1,0,1,0);
    for (int i = 0; i < 3; i++) add(0,1,0, 0,1,0,1,0);
    add(0,1,0, 1,2,0,1,0);
    for (int i = 0; i < 3; i++) add(0,1,0, 0,2,0,1,0);
    add(0,1,0, 1,3,1,1,0);
    for (int i = 0; i < 2; i++) add(0,1,0, 0,3,1,1,0);
    add(0,1,0, 1,4,1,1,0);
    for (int i = 0; i < 2; i++) add(0,1,0, 0,4,1,1,0);
    add(0,1,0, 1,5,2,1,0);
    add(0,1,0, 0,5,2,1,0);
    add(0,1,0, 1,6,2,0,1);
    for (int i = 0; i < 3; i++) add(0,1,0, 0,6,2,0,1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      bus.SC_LEVELTIMER_START_InLow  = vecs[i].start;
      bus.SC_LEVELTIMER_CRASH_InHigh = vecs[i].crash;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].tick, vecs[i].lv, vecs[i].band,
              vecs[i].run, vecs[i].done);
    end

    // Restart from DONE.
    bus.SC_LEVELTIMER_START_InLow = 1'b0;
    step();
    chk_all("restart", 0, 0, 0, 1, 0);
    bus.SC_LEVELTIMER_START_InLow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("restart.no_early_tick", int'(bus.SC_LEVELTIMER_TICK_OutHigh), 0);
    end
    step();
    chk_all("restart.first_tick", 1, 1, 0, 1, 0);

    // Crash pause two cycles after LV=1: next tick is 6 cycles late.
    step();
    step();
    bus.SC_LEVELTIMER_CRASH_InHigh = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("pause", 0, 1, 0, 0, 0);
    end
    bus.SC_LEVELTIMER_CRASH_InHigh = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      step();
      n++;
      if (bus.SC_LEVELTIMER_TICK_OutHigh) found = 1'b1;
    end
    chk("pause.resume_latency", n, 3);
    chk("pause.level", int'(bus.SC_LEVELTIMER_LEVEL_Out), 2);

    // Crash on the terminal count edge suppresses the tick.
    for (int i = 0; i < 3; i++) step();
    bus.SC_LEVELTIMER_CRASH_InHigh = 1'b1;
    step();
    chk_all("term_crash", 0, 2, 0, 0, 0);
    bus.SC_LEVELTIMER_CRASH_InHigh = 1'b0;
    step();
    chk_all("term_resume", 0, 2, 0, 1, 0);
    step();
    chk_all("term_tick", 1, 3, 1, 1, 0);

    // Reset with LV=3 and the timer mid-count.
    step();
    rst = 1'b1;
    step();
    chk_all("reset_mid", 0, 0, 0, 0, 0);
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.SC_LEVELTIMER_TICK_OutHigh) ticks++;
    end
    chk("reset_mid.no_ticks", ticks, 0);
    chk("reset_mid.idle", int'(bus.SC_LEVELTIMER_RUNNING_OutHigh), 0);

    // Held start: one run entry; held level does not restart from DONE.
    bus.SC_LEVELTIMER_START_InLow = 1'b0;
    ticks = 0;
    entries = 0;
    for (int i = 0; i < 50; i++) begin
      prev_run = bus.SC_LEVELTIMER_RUNNING_OutHigh;
      step();
      if (!prev_run && bus.SC_LEVELTIMER_RUNNING_OutHigh) entries++;
      if (bus.SC_LEVELTIMER_TICK_OutHigh) ticks++;
    end
    chk("held.entries", entries, 1);
    chk("held.ticks", ticks, 6);
    chk_all("held.end", 0, 6, 2, 0, 1);

    // Re-press during RUN is ignored.
    bus.SC_LEVELTIMER_START_InLow = 1'b1;
    step();
    bus.SC_LEVELTIMER_START_InLow = 1'b0;
    step();
    chk_all("repress.enter", 0, 0, 0, 1, 0);
    bus.SC_LEVELTIMER_START_InLow = 1'b1;
    step();
    step();
    bus.SC_LEVELTIMER_START_InLow = 1'b0;
    step();
    chk_all("repress.ignored", 0, 0, 0, 1, 0);
    step();
    chk_all("repress.tick", 1, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
